// File: rtl/pipeline_pkg.sv
// Shared definitions for the memory stage: funct3 access codes and LSU states.
package pipeline_pkg;

  // RV32I load/store funct3 encodings (size in [1:0], unsigned flag in [2])
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // IDLE accepts a new EX/MEM slot; MERGE writes back a read-modify-write word
  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/pipeline_lsu_if.sv
// Word-addressed data memory port: combinational read, single-cycle word write.
interface pipeline_lsu_if #(
  parameter int XLEN = 32
) ();

  logic [XLEN-1:0] dm_address;
  logic [XLEN-1:0] dm_write_data;
  logic            dm_read;
  logic            dm_write;
  logic [XLEN-1:0] dm_read_data;

  modport master (
    output dm_address,
    output dm_write_data,
    output dm_read,
    output dm_write,
    input  dm_read_data
  );

  modport slave (
    input  dm_address,
    input  dm_write_data,
    input  dm_read,
    input  dm_write,
    output dm_read_data
  );

endinterface

// File: rtl/pipeline_lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and extends it to XLEN.
module load_align
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the byte lane and the halfword lane named by the low address bits
  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  // Sign- or zero-extend by access type; undefined encodings read the whole word
  always_comb begin
    data = word;
    case (funct3)
      F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
      F3_W:    data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/pipeline_lsu.sv
// Memory stage: turns RV32I loads/stores into word accesses and registers MEM/WB.
// Sub-word stores are a read-modify-write spread over an IDLE and a MERGE cycle.
module pipeline_lsu
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  ex_wdata,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  pipeline_lsu_if.master   dm,
  output logic             stall,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_misaligned
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] mrg_addr_q, mrg_addr_d;
  logic [XLEN-1:0] mrg_data_q, mrg_data_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_misaligned_q, wb_misaligned_d;

  logic [XLEN-1:0] word_addr;
  logic [1:0]      lane;
  logic            is_op, is_byte, is_half, misaligned;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;
  logic [XLEN-1:0] dm_address_o, dm_write_data_o;
  logic            dm_read_o, dm_write_o;

  assign word_addr = {ex_result[XLEN-1:2], 2'b00};
  assign lane      = ex_result[1:0];

  load_align #(.XLEN(XLEN)) u_load_align (
    .word   (dm.dm_read_data),
    .lane   (lane),
    .funct3 (ex_funct3),
    .data   (load_data)
  );

  // Decode access size and alignment; anything not B/H behaves as a word access
  always_comb begin
    is_op      = ex_valid & (ex_mem_read | ex_mem_write);
    is_byte    = (ex_funct3 == F3_B) || (ex_funct3 == F3_BU);
    is_half    = (ex_funct3 == F3_H) || (ex_funct3 == F3_HU);
    misaligned = 1'b0;
    if (is_half) begin
      misaligned = lane[0];
    end else if (!is_byte) begin
      misaligned = (lane != 2'b00);
    end
  end

  // Replace the addressed lane(s) of the freshly read word with the store data
  always_comb begin
    merged_word = dm.dm_read_data;
    if (is_byte) begin
      case (lane)
        2'd0:    merged_word[7:0]   = ex_wdata[7:0];
        2'd1:    merged_word[15:8]  = ex_wdata[7:0];
        2'd2:    merged_word[23:16] = ex_wdata[7:0];
        default: merged_word[31:24] = ex_wdata[7:0];
      endcase
    end else if (lane[1]) begin
      merged_word[31:16] = ex_wdata[15:0];
    end else begin
      merged_word[15:0] = ex_wdata[15:0];
    end
  end

  // Next state, memory strobes, stall and next MEM/WB contents; reset kills strobes
  always_comb begin
    state_d         = state_q;
    mrg_addr_d      = mrg_addr_q;
    mrg_data_d      = mrg_data_q;
    dm_address_o    = word_addr;
    dm_write_data_o = ex_wdata;
    dm_read_o       = 1'b0;
    dm_write_o      = 1'b0;
    stall           = 1'b0;
    wb_valid_d      = ex_valid;
    wb_rd_d         = ex_rd;
    wb_reg_write_d  = ex_valid & ex_reg_write;
    wb_data_d       = ex_result;
    wb_misaligned_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_op) begin
          if (misaligned) begin
            wb_misaligned_d = 1'b1;
            wb_reg_write_d  = 1'b0;
          end else if (ex_mem_write) begin
            wb_reg_write_d = 1'b0;
            if (is_byte || is_half) begin
              dm_read_o  = 1'b1;
              stall      = 1'b1;
              mrg_addr_d = word_addr;
              mrg_data_d = merged_word;
              wb_valid_d = 1'b0;
              state_d    = MERGE;
            end else begin
              dm_write_o = 1'b1;
            end
          end else begin
            dm_read_o = 1'b1;
            wb_data_d = load_data;
          end
        end
      end
      MERGE: begin
        dm_address_o    = mrg_addr_q;
        dm_write_data_o = mrg_data_q;
        dm_write_o      = 1'b1;
        wb_valid_d      = 1'b1;
        wb_rd_d         = '0;
        wb_reg_write_d  = 1'b0;
        wb_data_d       = '0;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      dm_read_o  = 1'b0;
      dm_write_o = 1'b0;
      stall      = 1'b0;
    end
  end

  // State, pending merge and MEM/WB registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      mrg_addr_q      <= '0;
      mrg_data_q      <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_data_q       <= '0;
      wb_misaligned_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      mrg_addr_q      <= mrg_addr_d;
      mrg_data_q      <= mrg_data_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_data_q       <= wb_data_d;
      wb_misaligned_q <= wb_misaligned_d;
    end
  end

  assign dm.dm_address    = dm_address_o;
  assign dm.dm_write_data = dm_write_data_o;
  assign dm.dm_read       = dm_read_o;
  assign dm.dm_write      = dm_write_o;

  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_data       = wb_data_q;
  assign wb_misaligned = wb_misaligned_q;

endmodule
